// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader with checksum that fills instruction RAM, then releases the core
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] pc,
  output logic [12:0]       inst,
  output logic              core_reset,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   count
);
  typedef enum logic [2:0] {IDLE, HI, LO, CHK, RUN, ERR} state_t;
  state_t state;
  logic [12:0] mem [2**ADDR_W];
  logic [ADDR_W:0] n, idx, n_in;
  logic [4:0] hi;
  logic [7:0] sum;
  logic fire, we;
  assign fire = in_valid && in_ready;
  // gating with reset keeps an aborted load from writing on the edge it is reset
  assign we = fire && state == LO && reset;
  assign n_in = in_data == 8'd0 ? (ADDR_W+1)'(1) << ADDR_W : (ADDR_W+1)'(in_data);
  assign inst = (state == RUN && {1'b0, pc} < count) ? mem[pc] : 13'd0;
  always_ff @(posedge clk)
    if (we) mem[idx[ADDR_W-1:0]] <= {hi, in_data};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      n          <= '0;
      hi         <= '0;
      sum        <= '0;
      count      <= '0;
      error      <= 1'b0;
      busy       <= 1'b0;
      core_reset <= 1'b1;
      in_ready   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (fire) begin
          n     <= n_in;
          sum   <= in_data;
          busy  <= 1'b1;
          state <= HI;
        end
        HI: if (fire) begin
          sum <= sum ^ in_data;
          hi  <= in_data[4:0];
          if (in_data[7:5] != 3'd0) begin
            state    <= ERR;
            error    <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b0;
          end else state <= LO;
        end
        LO: if (fire) begin
          sum   <= sum ^ in_data;
          idx   <= idx + 1'b1;
          state <= (idx + 1'b1 == n) ? CHK : HI;
        end
        CHK: if (fire) begin
          busy     <= 1'b0;
          in_ready <= 1'b0;
          if (in_data == sum) begin
            state      <= RUN;
            core_reset <= 1'b0;
            count      <= n;
          end else begin
            state <= ERR;
            error <= 1'b1;
          end
        end
        RUN, ERR: if (reload) begin
          state      <= IDLE;
          error      <= 1'b0;
          idx        <= '0;
          sum        <= '0;
          core_reset <= 1'b1;
          in_ready   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed table, corner sequences and randomized loads against a stream-level model
module tb_prog_loader;
  logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, reload = 1'b0;
  logic [7:0]  in_data = 8'd0, pc = 8'd0;
  logic        in_ready, core_reset, busy, error;
  logic [12:0] inst;
  logic [8:0]  count;
  int vectors = 0, miscompares = 0;
  logic [12:0] ref_mem [256];
  int ref_count = 0;

  prog_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reload(reload), .pc(pc), .inst(inst), .core_reset(core_reset), .busy(busy),
    .error(error), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          len;
    logic [63:0] b;
    int          gap;
    logic        err;
    logic        cr;
    int          cnt;
    int          i0;
    int          i1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit rl);
    in_data  = b;
    in_valid = 1'b1;
    reload   = rl;
    tick;
    in_valid = 1'b0;
    reload   = 1'b0;
    in_data  = 8'($urandom);
    repeat (gap) tick;
  endtask

  task automatic pulse_reload;
    reload = 1'b1;
    tick;
    reload = 1'b0;
  endtask

  // Interprets a whole byte stream: words land at consecutive addresses, checksum is the XOR of all earlier bytes
  task automatic mdl(input logic [7:0] s[$], output int used, output bit ok);
    int n;
    logic [7:0] x, h, l;
    n = (s[0] == 8'd0) ? 256 : int'(s[0]);
    x = s[0];
    used = 1;
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      h = s[used];
      used++;
      x ^= h;
      if (h[7:5] != 3'd0) return;
      l = s[used];
      used++;
      x ^= l;
      ref_mem[i] = {h[4:0], l};
    end
    ok = (s[used] == x);
    used++;
    if (ok) ref_count = n;
  endtask

  function automatic logic [12:0] exp_inst(input int p, input bit run);
    return (run && p < ref_count) ? ref_mem[p] : 13'd0;
  endfunction

  initial begin
    vec_t tv[7];
    logic [63:0] bv;
    logic [7:0] q[$];
    logic [7:0] x, h;
    int used, n, fault, bad;
    bit ok;
    tv[0] = '{4, 64'h0101020200000000, 0, 1'b0, 1'b0, 1, 'h102, 0};
    tv[1] = '{4, 64'h0101020700000000, 0, 1'b1, 1'b1, 1, 0, 0};
    tv[2] = '{2, 64'h0120000000000000, 0, 1'b1, 1'b1, 1, 0, 0};
    tv[3] = '{6, 64'h021FFF0001E30000, 0, 1'b0, 1'b0, 2, 'h1FFF, 'h0001};
    tv[4] = '{8, 64'h0301100220033003, 0, 1'b0, 1'b0, 3, 'h110, 'h220};
    tv[5] = '{6, 64'h020005A006A20000, 0, 1'b1, 1'b1, 3, 0, 0};
    tv[6] = '{8, 64'h0301100220033003, 1, 1'b0, 1'b0, 3, 'h110, 'h220};

    repeat (2) tick;
    check("rst in_ready", in_ready, 1);
    check("rst core_reset", core_reset, 1);
    check("rst busy", busy, 0);
    check("rst error", error, 0);
    check("rst count", count, 0);
    check("rst inst", inst, 0);
    reload = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h05;
    tick;
    reload = 1'b0;
    in_valid = 1'b0;
    check("rst priority busy", busy, 0);
    reset = 1'b1;
    tick;
    pulse_reload;
    check("idle reload in_ready", in_ready, 1);
    check("idle reload busy", busy, 0);

    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        pulse_reload;
        check("reload error", error, 0);
        check("reload in_ready", in_ready, 1);
        check("reload core_reset", core_reset, 1);
      end
      bv = tv[k].b;
      for (int i = 0; i < tv[k].len; i++) send(bv[63-8*i -: 8], tv[k].gap, 1'b0);
      check("tbl error", error, tv[k].err);
      check("tbl core_reset", core_reset, tv[k].cr);
      check("tbl busy", busy, 0);
      check("tbl in_ready", in_ready, 0);
      check("tbl count", count, tv[k].cnt);
      pc = 8'd0;
      #1 check("tbl inst0", inst, tv[k].i0);
      pc = 8'd1;
      #1 check("tbl inst1", inst, tv[k].i1);
    end

    pulse_reload;
    send(8'h01, 0, 1'b0);
    send(8'hE0, 0, 1'b0);
    check("bad hi error", error, 1);
    check("bad hi busy", busy, 0);
    check("bad hi no write", dut.mem[0], 'h110);
    check("bad hi count", count, 3);

    pulse_reload;
    send(8'h03, 0, 1'b0);
    check("load busy", busy, 1);
    check("load in_ready", in_ready, 1);
    check("load core_reset", core_reset, 1);
    repeat (5) begin
      in_data = 8'($urandom);
      tick;
    end
    check("stall busy", busy, 1);
    check("stall error", error, 0);
    send(8'h04, 0, 1'b0);
    send(8'h44, 0, 1'b0);
    send(8'h05, 0, 1'b1);
    send(8'h55, 0, 1'b0);
    reset = 1'b0;
    #1;
    check("abort in_ready", in_ready, 1);
    check("abort core_reset", core_reset, 1);
    check("abort busy", busy, 0);
    check("abort count", count, 0);
    check("abort word0", dut.mem[0], 'h444);
    check("abort word1", dut.mem[1], 'h555);
    check("abort word2", dut.mem[2], 'h330);
    tick;
    reset = 1'b1;
    tick;

    q = {8'h00};
    x = 8'h00;
    for (int i = 0; i < 512; i++) begin
      h = (i % 2 == 0) ? 8'($urandom) & 8'h1F : 8'($urandom);
      q.push_back(h);
      x ^= h;
    end
    q.push_back(x);
    mdl(q, used, ok);
    for (int i = 0; i < used; i++) send(q[i], 0, 1'b0);
    check("full count", count, 256);
    check("full core_reset", core_reset, 0);
    check("full error", error, 0);
    for (int p = 0; p < 256; p++) begin
      pc = 8'(p);
      #1 check("full inst", inst, exp_inst(p, 1'b1));
    end

    for (int t = 0; t < 30; t++) begin
      pulse_reload;
      n = $urandom_range(1, 24);
      fault = $urandom_range(0, 3);
      bad = $urandom_range(0, n - 1);
      q = {8'(n)};
      x = 8'(n);
      for (int i = 0; i < n; i++) begin
        h = 8'($urandom) & 8'h1F;
        if (fault == 0 && i == bad) h |= 8'($urandom_range(1, 7)) << 5;
        q.push_back(h);
        x ^= h;
        h = 8'($urandom);
        q.push_back(h);
        x ^= h;
      end
      q.push_back(fault == 1 ? x ^ 8'($urandom_range(1, 255)) : x);
      mdl(q, used, ok);
      for (int i = 0; i < used; i++) send(q[i], $urandom_range(0, 2), $urandom_range(0, 7) == 0);
      check("rnd error", error, !ok);
      check("rnd core_reset", core_reset, !ok);
      check("rnd busy", busy, 0);
      check("rnd in_ready", in_ready, 0);
      check("rnd count", count, ref_count);
      pc = 8'(n);
      #1 check("rnd inst edge", inst, exp_inst(n, ok));
      for (int j = 0; j < 3; j++) begin
        pc = 8'($urandom_range(0, n + 1));
        #1 check("rnd inst", inst, exp_inst(int'(pc), ok));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-address width; depth is 2**ADDR_W words of 13 bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_data  input  8  loader byte stream.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port reload  input  1  one-cycle request to start a new load.
REQ-008 SHALL have port pc  input  ADDR_W  core fetch address.
REQ-009 SHALL have port inst  output  13  instruction at pc, combinational.
REQ-010 SHALL have port core_reset  output  1  active-high hold for the core.
REQ-011 SHALL have port busy  output  1  high while a load is in progress.
REQ-012 SHALL have port error  output  1  sticky load-failure flag.
REQ-013 SHALL have port count  output  ADDR_W+1  number of instructions loaded.

Function
REQ-014 SHALL implement FSM states IDLE, HI, LO, CHK, RUN, ERR.
REQ-015 SHALL transfer a byte only on a cycle with in_valid and in_ready both high.
REQ-016 SHALL drive in_ready high in IDLE, HI, LO, CHK and low in RUN, ERR.
REQ-017 SHALL, in IDLE, accept byte N as the instruction count (0 means 2**ADDR_W), latch it, seed the checksum with N, and move to HI.
REQ-018 SHALL, in HI, accept the high byte and move to LO; if bits [7:5] are nonzero, it SHALL move to ERR instead.
REQ-019 SHALL, in LO, accept the low byte and write {hi[4:0], lo} to RAM word idx on that same clock edge.
REQ-020 SHALL increment idx after each LO write and move to CHK after the Nth word; otherwise it SHALL return to HI.
REQ-021 SHALL XOR every accepted byte into an 8-bit running checksum, excluding the checksum byte itself.
REQ-022 SHALL, in CHK, accept one byte and move to RUN if it equals the running checksum; otherwise it SHALL move to ERR.
REQ-023 SHALL hold core_reset high in every state except RUN, deasserting it on the first cycle in RUN.
REQ-024 SHALL drive busy high in HI, LO, CHK.
REQ-025 SHALL set error on entry to ERR and clear it only on reset or accepted reload.
REQ-026 SHALL return to IDLE on reload in RUN or ERR, clearing error, idx and checksum; reload SHALL be ignored in IDLE, HI, LO, CHK.
REQ-027 SHALL update count to N on entry to RUN only; count SHALL keep its previous value during a load and after ERR.
REQ-028 SHALL make inst = RAM[pc] when state is RUN and pc < count, and 13'b0 otherwise.
REQ-029 SHALL make a RAM word written on edge k visible on inst from cycle k+1.
REQ-030 SHALL never leave RAM contents undefined by control: writes occur only per REQ-019.
REQ-031 SHALL, for N=2**ADDR_W, write addresses 0..2**ADDR_W-1 with no wrap and no extra write.
REQ-032 SHALL ignore in_data when in_valid is low and stall indefinitely without state change.

Reset
REQ-033 SHALL, while reset is low, force state IDLE, idx 0, checksum 0, count 0, error 0, busy 0, core_reset 1, in_ready 1 (IDLE).
REQ-034 SHALL leave RAM contents unchanged by reset.
REQ-035 SHALL, when reset asserts during a load, abort the load with no further RAM write and restart from IDLE.
REQ-036 SHALL give reset priority over reload and over any byte transfer in the same cycle.

Verification
REQ-037 SHALL pass: stream 0x01,0x01,0x02,0x02 -> word0=0x102, RUN, core_reset 0, count 1, inst(pc=0)=0x0102, inst(pc=1)=0.
REQ-038 SHALL pass: stream 0x01,0x01,0x02,0x07 -> ERR, error 1, core_reset 1, count unchanged; then reload -> IDLE, error 0.
REQ-039 SHALL pass: stream 0x01,0x20 -> ERR immediately after the high byte, with no RAM write.
REQ-040 SHALL pass: in_valid toggled 1/0 each cycle through a 3-word load -> same RAM image and checksum result as a back-to-back load.
REQ-041 SHALL pass: reset low after the second LO byte of N=3 -> IDLE, core_reset 1, RAM words 0-1 retained, word 2 unwritten.
REQ-042 SHALL pass: N=0x00 (256 words) with the correct checksum -> RUN, count 256, word 255 readable, no write past word 255.
